prime_checker_seq: RTL and testbench
====================================

# prime_checker_seq

Sequential, parametrised prime checker: accepts one WIDTH-bit unsigned operand per valid/ready handshake and tests it by trial division, one divisor per clock. It returns a registered prime/not-prime verdict through an output valid/ready handshake. It is the generalised successor to our fixed 8-bit, single-cycle prime detector, and is intended for streaming datapaths where a combinational full-range modulo loop is too large or too slow.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 4..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; asynchronous assert, active-low.
- `in_valid`  input  1  operand offered.
- `in_ready`  output  1  block can accept an operand.
- `in_number`  input  WIDTH  unsigned operand.
- `out_valid`  output  1  verdict available.
- `out_ready`  input  1  consumer accepts the verdict.
- `out_is_prime`  output  1  1 means the operand is prime.
- `out_number`  output  WIDTH  echo of the operand being reported.
- `out_factor`  output  WIDTH  present only with `PRIME_FACTOR_EN`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CHECK: trial loop.
  - DONE: `out_valid`=1.
- IDLE: when `in_valid && in_ready`, register n = `in_number`, then classify:
  - n<2: not prime, go to DONE.
  - n==2 or n==3: prime, go to DONE.
  - n even and n>3: not prime, go to DONE.
  - Otherwise: set d=3 and go to CHECK.
- CHECK: evaluate one divisor per cycle.
  - d*d > n: prime, go to DONE.
  - Else, n % d == 0: not prime, go to DONE.
  - Else: d = d+2 and stay in CHECK.
- Arithmetic widths:
  - d is WIDTH bits.
  - d*d is computed at 2*WIDTH bits; no overflow is possible in the legal range.
  - The remainder is unsigned and WIDTH bits.
- DONE: hold `out_valid`, `out_is_prime` and `out_number` stable until `out_ready`=1. Then go to IDLE.
- `in_ready` is low in CHECK and DONE. Only one operand is in flight. An operand offered in DONE is not accepted until IDLE.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_is_prime`=0, `out_number`=0, `out_factor`=0, d=0.
- Reset asserted mid-CHECK or mid-DONE aborts the operation. No verdict is emitted for the aborted operand.

## Timing
- Cycle 0 is the acceptance edge. All outputs are registered; there is no combinational path from inputs to outputs.
- Trivial cases (n<2, n==2, n==3, n even): `out_valid` rises at cycle 1.
- Odd n ≥ 5: the loop runs k CHECK cycles, where k counts divisors 3, 5, … up to and including the deciding divisor. `out_valid` rises at cycle k+1.
- Worst case at WIDTH=8 is about 8 CHECK cycles, for n=251.
- DONE to IDLE takes 1 cycle after `out_ready` is sampled high. The earliest next acceptance is the following cycle.
- `out_ready` may be held high permanently; back-to-back throughput is then latency+1 cycles per operand.

## Configuration
- `PRIME_FACTOR_EN` defined:
  - The `out_factor` port exists and is valid with `out_valid`.
  - It carries the smallest prime factor for composites (2 for even n>3, otherwise the deciding d).
  - It is 0 for primes and for n<2.
- `PRIME_FACTOR_EN` undefined: no `out_factor` port and no factor register. The verdict and timing are identical.

## Structure
- The shared package `prime_pkg` holds:
  - the state enum typedef (IDLE, CHECK, DONE);
  - the `FIRST_ODD_DIVISOR`=3 constant;
  - the `MIN_WIDTH`=4 constant.
- One sub-module, `prime_trial_step`. It is purely combinational and parametrised by WIDTH.
  - Inputs: n, d.
  - Outputs: `sq_over` (d*d > n) and `divides` (n%d==0).
- The FSM, registers and handshake live in `prime_checker_seq`.

## Test plan
- Reset then trivial operands, WIDTH=8:
  - n=0 and n=1 give `out_is_prime`=0.
  - n=2 and n=3 give `out_is_prime`=1.
  - n=4 gives 0 (factor 2).
  - All report with `out_valid` at cycle 1.
- Loop cases, WIDTH=8:
  - n=7 → prime at cycle 2.
  - n=9 → not prime at cycle 2 (factor 3).
  - n=25 → not prime at cycle 3 (factor 5).
  - n=251 → prime at cycle 9.
- Backpressure: n=13 with `out_ready`=0 for 5 cycles.
  - `out_valid`, `out_is_prime`=1 and `out_number`=13 stay stable.
  - `in_ready` stays 0 while a second `in_valid` is ignored.
- Reset mid-CHECK: apply n=251, assert `rst_n`=0 at cycle 4.
  - All outputs return to reset values immediately.
  - No verdict for 251 appears.
  - Next, n=11 → prime.
- Exhaustive sweep at WIDTH=8 and WIDTH=12 against a software reference with random `out_ready`.
  - Every verdict matches.
  - Latency matches the formula.
  - With `PRIME_FACTOR_EN`, `out_factor` matches the smallest prime factor.

Source files
------------

// File: rtl/prime_pkg.sv
// prime_pkg: shared definitions for the sequential prime checker.
//   prime_state_e      - controller states (IDLE, CHECK, DONE)
//   FIRST_ODD_DIVISOR  - first divisor tried by the trial loop
//   MIN_WIDTH/MAX_WIDTH - legal operand width range
package prime_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } prime_state_e;

    localparam int FIRST_ODD_DIVISOR = 3;
    localparam int MIN_WIDTH         = 4;
    localparam int MAX_WIDTH         = 32;

endpackage

// File: rtl/prime_trial_step.sv
// prime_trial_step: combinational evaluation of one trial-division step.
// Ports:
//   n        (in,  WIDTH)  operand under test
//   d        (in,  WIDTH)  current odd divisor
//   sq_over  (out, 1)      d*d > n, i.e. no divisor up to sqrt(n) remains
//   divides  (out, 1)      n % d == 0 (forced low for d == 0)
module prime_trial_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic             sq_over,
    output logic             divides
);

    logic [2*WIDTH-1:0] d_ext;
    logic [2*WIDTH-1:0] n_ext;
    logic [2*WIDTH-1:0] d_sq;
    logic [WIDTH-1:0]   rem;

    // The square is formed at double width so it cannot wrap for any d.
    assign d_ext = {{WIDTH{1'b0}}, d};
    assign n_ext = {{WIDTH{1'b0}}, n};
    assign d_sq  = d_ext * d_ext;

    assign sq_over = (d_sq > n_ext);

    // Guard the zero divisor so the remainder is always defined.
    assign rem     = (d == '0) ? n : (n % d);
    assign divides = (d != '0) && (rem == '0);

endmodule

// File: rtl/prime_checker_seq.sv
// prime_checker_seq: sequential trial-division prime checker.
// Accepts one operand per input handshake, tests odd divisors 3, 5, 7, ...
// one per clock, and presents a registered verdict on the output handshake.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE, where out_is_prime/out_number/out_factor hold until out_ready.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      (in)  operand offered
//   in_ready      (out) block idle and able to accept
//   in_number     (in)  WIDTH-bit unsigned operand
//   out_valid     (out) verdict available
//   out_ready     (in)  consumer takes the verdict
//   out_is_prime  (out) 1 when the operand is prime
//   out_number    (out) echo of the reported operand
//   out_factor    (out) smallest prime factor, 0 for primes and n<2;
//                       present only when PRIME_FACTOR_EN is defined
//
// Build option: define PRIME_FACTOR_EN to add the out_factor port/register.
module prime_checker_seq
    import prime_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_prime,
    output logic [WIDTH-1:0] out_number
`ifdef PRIME_FACTOR_EN
    ,
    output logic [WIDTH-1:0] out_factor
`endif
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("prime_checker_seq: WIDTH out of legal range");
    end

    localparam logic [WIDTH-1:0] C_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] C_THREE = WIDTH'(3);
    localparam logic [WIDTH-1:0] C_FIRST = WIDTH'(FIRST_ODD_DIVISOR);
    localparam logic [WIDTH-1:0] C_STEP  = WIDTH'(2);

    prime_state_e     state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             prime_q, prime_d;
`ifdef PRIME_FACTOR_EN
    logic [WIDTH-1:0] factor_q, factor_d;
`endif

    logic sq_over;
    logic divides;

    prime_trial_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .n       (n_q),
        .d       (d_q),
        .sq_over (sq_over),
        .divides (divides)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            d_q      <= '0;
            prime_q  <= 1'b0;
`ifdef PRIME_FACTOR_EN
            factor_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            d_q      <= d_d;
            prime_q  <= prime_d;
`ifdef PRIME_FACTOR_EN
            factor_q <= factor_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        d_d      = d_q;
        prime_d  = prime_q;
`ifdef PRIME_FACTOR_EN
        factor_d = factor_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d = in_number;
                    // Small and even operands are settled without the loop.
                    if (in_number < C_TWO) begin
                        prime_d  = 1'b0;
`ifdef PRIME_FACTOR_EN
                        factor_d = '0;
`endif
                        state_d  = DONE;
                    end else if (in_number == C_TWO || in_number == C_THREE) begin
                        prime_d  = 1'b1;
`ifdef PRIME_FACTOR_EN
                        factor_d = '0;
`endif
                        state_d  = DONE;
                    end else if (!in_number[0]) begin
                        prime_d  = 1'b0;
`ifdef PRIME_FACTOR_EN
                        factor_d = C_TWO;
`endif
                        state_d  = DONE;
                    end else begin
                        d_d     = C_FIRST;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                // Square test first: once d*d > n no factor can remain.
                if (sq_over) begin
                    prime_d  = 1'b1;
`ifdef PRIME_FACTOR_EN
                    factor_d = '0;
`endif
                    state_d  = DONE;
                end else if (divides) begin
                    prime_d  = 1'b0;
`ifdef PRIME_FACTOR_EN
                    factor_d = d_q;
`endif
                    state_d  = DONE;
                end else begin
                    // Only odd divisors: n is odd here. d stays below
                    // sqrt(2^WIDTH)+2, so the add cannot wrap.
                    d_d = d_q + C_STEP;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_is_prime = prime_q;
    assign out_number   = n_q;
`ifdef PRIME_FACTOR_EN
    assign out_factor   = factor_q;
`else
    // No factor register in this build; the verdict path is unchanged.
`endif

endmodule

// File: tb/tb_prime_checker_seq.sv
// tb_prime_checker_seq: self-checking bench for prime_checker_seq (WIDTH=8).
// Directed trivial/loop/backpressure/reset cases, an exhaustive operand sweep
// and a random phase, all scored against an arithmetic reference model.
module tb_prime_checker_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_number = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_is_prime;
    logic [W-1:0] out_number;
`ifdef PRIME_FACTOR_EN
    logic [W-1:0] out_factor;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    prime_checker_seq #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_number    (in_number),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_is_prime (out_is_prime),
        .out_number   (out_number)
`ifdef PRIME_FACTOR_EN
        ,
        .out_factor   (out_factor)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int ref_spf(input int n);
        if (n < 2) return 0;
        for (int i = 2; i * i <= n; i++) begin
            if (n % i == 0) return i;
        end
        return n;
    endfunction

    function automatic int ref_prime(input int n);
        return (n >= 2 && ref_spf(n) == n) ? 1 : 0;
    endfunction

    function automatic int ref_factor(input int n);
        return (n < 2 || ref_prime(n) == 1) ? 0 : ref_spf(n);
    endfunction

    // Cycles from acceptance edge to out_valid: 1 for trivial operands,
    // otherwise (number of odd divisors tried from 3 to the deciding one) + 1.
    function automatic int ref_latency(input int n);
        int m;
        if (n < 4 || (n % 2) == 0) return 1;
        if (ref_prime(n) == 0) return (ref_spf(n) - 1) / 2 + 1;
        m = 3;
        while (m * m <= n) m += 2;
        return (m - 1) / 2 + 1;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Offers n, waits for the verdict, stalls out_ready for 'stall' cycles
    // (0 = out_ready held high from the start), optionally offering a second
    // operand during the stall, then completes the output handshake.
    task automatic run_op(input int n, input int stall, input bit poke);
        int cyc;
        logic [W-1:0] exp_n;
        logic [W-1:0] held_n;
        logic         held_p;
        check("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_number = W'(n);
        out_ready = (stall == 0);
        exp_q.push_back(W'(n));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_in_ready", in_ready, 0);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, ref_latency(n));
        if (!out_valid) begin
            exp_q.delete();
            return;
        end
        check("queue_nonempty", exp_q.size(), 1);
        exp_n = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("out_number", out_number, exp_n);
        check("out_is_prime", out_is_prime, ref_prime(n));
`ifdef PRIME_FACTOR_EN
        check("out_factor", out_factor, ref_factor(n));
`endif
        held_n = out_number;
        held_p = out_is_prime;
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                in_valid  = 1'b1;
                in_number = W'($urandom_range(0, (1 << W) - 1));
            end
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_number", out_number, held_n);
            check("stall_prime", out_is_prime, held_p);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int directed[9] = '{0, 1, 2, 3, 4, 7, 9, 25, 251};
        bit seen;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_prime", out_is_prime, 0);
        check("rst_out_number", out_number, 0);
`ifdef PRIME_FACTOR_EN
        check("rst_out_factor", out_factor, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Trivial and loop cases.
        foreach (directed[i]) run_op(directed[i], 0, 1'b0);

        // Backpressure with a second offer ignored while busy.
        run_op(13, 5, 1'b1);

        // Reset in the middle of the trial loop for 251.
        check("abort_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_number = W'(251);
        out_ready = 1'b1;
        exp_q.push_back(W'(251));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_in_ready_rst", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_prime", out_is_prime, 0);
        check("abort_out_number", out_number, 0);
`ifdef PRIME_FACTOR_EN
        check("abort_out_factor", out_factor, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_verdict", seen, 0);
        out_ready = 1'b0;
        run_op(11, 1, 1'b0);

        // Exhaustive sweep with random backpressure.
        for (int n = 0; n < (1 << W); n++) begin
            run_op(n, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
        end

        // Random operands.
        repeat (40) begin
            run_op($urandom_range(0, (1 << W) - 1), $urandom_range(0, 3), 1'b1);
        end

        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
